ethernet_tx: RTL and testbench
==============================

# ethernet_tx

Serial Ethernet frame transmitter; the upstream stage of the `Ethernet` receiver. It latches a frame descriptor from the host and emits the complete bitstream one bit per clock on `Output1`, in the exact order the receiver consumes:
- preamble,
- SFD,
- destination address,
- source address,
- EtherType,
- payload,
- CRC-32 FCS.

It then enforces an idle inter-frame gap.

## Interface

Parameters:
- `MAX_PAYLOAD`, default 64: payload buffer width in bits; largest legal `PayloadLen`.
- `IFG_CYCLES`, default 12: idle cycles after each frame before the next `Start` is accepted.

Ports:
- `Clk`  in  1  system clock; one serial bit per rising edge.
- `Reset`  in  1  asynchronous, active-low reset.
- `Start`  in  1  request to send; sampled only when `Busy`=0.
- `DestAddr`  in  48  destination MAC, latched on accepted `Start`.
- `SrcAddr`  in  48  source MAC, latched on accepted `Start`.
- `PayloadLen`  in  16  payload length in bits; sent verbatim as the EtherType field.
- `Payload`  in  `MAX_PAYLOAD`  payload bits; bit `PayloadLen-1` is sent first, bit 0 last.
- `Output1`  out  1  serial line; 0 when not transmitting.
- `TxValid`  out  1  high for every cycle `Output1` carries a frame bit.
- `Busy`  out  1  high from accepted `Start` through the end of the IFG.
- `Done`  out  1  one-cycle pulse in the cycle after the last FCS bit.
- `Error`  out  1  one-cycle pulse when `Start` is rejected because `PayloadLen` > `MAX_PAYLOAD`.

## Operation

- State machine: IDLE → PREAMBLE → SFD → DEST → SRC → TYPE → PAYLOAD → FCS → GAP → IDLE.
- A single bit counter is reloaded on each state entry.
- State lengths:
  - PREAMBLE: 62 bits, alternating, starting with 1 (1,0,1,0,…,1,0).
  - SFD: 2 bits, 1,1.
  - DEST: 48 bits, MSB first.
  - SRC: 48 bits, MSB first.
  - TYPE: 16 bits = `PayloadLen`, MSB first.
  - PAYLOAD: `PayloadLen` bits. The state is skipped entirely when `PayloadLen` = 0 (TYPE → FCS).
  - FCS: 32 bits, MSB first.
  - GAP: `IFG_CYCLES` cycles, `Output1`=0, `TxValid`=0.
- CRC-32 definition:
  - Polynomial 0x04C11DB7, non-reflected, bit-serial.
  - Register initialised to 0xFFFFFFFF on accepted `Start`.
  - Updated on every DEST, SRC, TYPE and PAYLOAD bit.
  - Transmitted value is the bitwise complement of the register, bit 31 first.
  - Preamble and SFD are excluded from the CRC.
- Frame length is 208 + `PayloadLen` bits.
- `Start` is accepted only in IDLE. While `Busy`=1 it is ignored; nothing is queued.
- If `PayloadLen` > `MAX_PAYLOAD` at `Start`: the block pulses `Error`, stays IDLE, and `Busy` stays 0.
- Descriptor inputs may change freely after the accept edge; the block transmits only from the latched copies.
- Reset (asynchronous, low) in any state forces IDLE, clears the CRC register and bit counter, and drives all outputs to 0. A partial frame is abandoned, not completed.

## Timing

- Reset values: `Output1`=0, `TxValid`=0, `Busy`=0, `Done`=0, `Error`=0.
- All outputs are registered.
- If `Start` is sampled high at edge k in IDLE:
  - `Busy`=1 and the first preamble bit (1) appear after edge k.
  - `TxValid` is high from edge k through edge k+207+`PayloadLen`.
- `Done`=1 for exactly one cycle, after edge k+208+`PayloadLen`. `TxValid` is 0 in that same cycle.
- GAP begins in the `Done` cycle and runs `IFG_CYCLES` cycles. `Busy` falls after edge k+208+`PayloadLen`+`IFG_CYCLES`.
- The earliest next accept is at the edge where `Busy` is first sampled 0. Minimum start-to-start spacing is 209 + `PayloadLen` + `IFG_CYCLES` cycles.
- `Error` pulses for the cycle after edge k; no other output changes.
- `Start` held high continuously sends back-to-back frames separated by exactly the IFG.

## Test plan

1. Reset mid-frame: assert `Reset` low during DEST at bit 20 → all outputs are 0 immediately (asynchronous). After release, `Start` produces a fresh frame whose preamble starts with 1.
2. Basic frame:
   - Stimulus: `DestAddr`=FFFFFFFFFFFF, `SrcAddr`=AAAAAAAAAAAA, `PayloadLen`=4, `Payload`[3:0]=4'b1000.
   - Required: 212 `TxValid` cycles.
   - Bit ranges: bits 1–62 alternate starting with 1; bits 63–64 = 1,1; bits 161–176 = 0x0004; bits 177–180 = 1,0,0,0.
   - Bits 181–212 match the bench CRC-32 model (complemented register).
   - `Done` pulses in cycle 213.
3. Zero payload: `PayloadLen`=0 → 208 `TxValid` cycles; TYPE = 0x0000 is followed directly by FCS; the FCS matches the model.
4. Maximum and oversize lengths:
   - `PayloadLen`=64 → 272-bit frame.
   - `PayloadLen`=65 → `Error` one cycle, `Busy` stays 0, `Output1` stays 0.
5. `Start` during `Busy`: pulse `Start` at bit 100 with a different `DestAddr` → ignored. The current frame is unchanged, and no second frame follows after the IFG.
6. Back-to-back: hold `Start` high with `PayloadLen`=4, `IFG_CYCLES`=12 → the second frame's first bit appears exactly 225 cycles after the first frame's first bit, with an identical FCS.

Source files
------------

// File: rtl/ethernet_tx.sv
// Serial Ethernet frame transmitter: preamble, SFD, addresses, EtherType,
// payload and CRC-32 FCS, one bit per clock, followed by an idle gap.
module ethernet_tx #(
  parameter int unsigned MAX_PAYLOAD = 64,
  parameter int unsigned IFG_CYCLES  = 12
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic                   Start,
  input  logic [47:0]            DestAddr,
  input  logic [47:0]            SrcAddr,
  input  logic [15:0]            PayloadLen,
  input  logic [MAX_PAYLOAD-1:0] Payload,
  output logic                   Output1,
  output logic                   TxValid,
  output logic                   Busy,
  output logic                   Done,
  output logic                   Error
);

  localparam int unsigned CW = 16;
  localparam logic [CW-1:0] PRE_LAST  = CW'(61);
  localparam logic [CW-1:0] SFD_LAST  = CW'(1);
  localparam logic [CW-1:0] ADDR_LAST = CW'(47);
  localparam logic [CW-1:0] TYPE_LAST = CW'(15);
  localparam logic [CW-1:0] FCS_LAST  = CW'(31);
  localparam logic [CW-1:0] IFG_LAST  = CW'(IFG_CYCLES - 1);
  localparam logic [15:0]   MAX_LEN   = 16'(MAX_PAYLOAD);
  localparam logic [31:0]   POLY      = 32'h04C1_1DB7;

  typedef enum logic [3:0] {
    S_IDLE, S_PRE, S_SFD, S_DEST, S_SRC, S_TYPE, S_PAY, S_FCS, S_GAP
  } state_t;

  state_t                 state;
  logic [CW-1:0]          cnt;
  logic [31:0]            crc;
  logic [47:0]            dest_sh;
  logic [47:0]            src_sh;
  logic [15:0]            type_sh;
  logic [15:0]            len_q;
  logic [MAX_PAYLOAD-1:0] pay_sh;

  // One step of the MSB-first, non-reflected CRC-32 shift register.
  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic b);
    crc_step = {c[30:0], 1'b0} ^ ((c[31] ^ b) ? POLY : 32'h0);
  endfunction

  // Frame sequencer: each edge emits the next line bit; cnt holds the number
  // of bits still to go in the field currently on the line.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state   <= S_IDLE;
      cnt     <= '0;
      crc     <= '0;
      dest_sh <= '0;
      src_sh  <= '0;
      type_sh <= '0;
      len_q   <= '0;
      pay_sh  <= '0;
      Output1 <= 1'b0;
      TxValid <= 1'b0;
      Busy    <= 1'b0;
      Done    <= 1'b0;
      Error   <= 1'b0;
    end else begin
      Done  <= 1'b0;
      Error <= 1'b0;
      case (state)
        S_IDLE: begin
          if (Start) begin
            if (PayloadLen > MAX_LEN) begin
              Error <= 1'b1;
            end else begin
              state   <= S_PRE;
              cnt     <= PRE_LAST;
              crc     <= '1;
              dest_sh <= DestAddr;
              src_sh  <= SrcAddr;
              type_sh <= PayloadLen;
              len_q   <= PayloadLen;
              // Left-align so payload bit PayloadLen-1 sits at the MSB.
              pay_sh  <= Payload << (MAX_LEN - PayloadLen);
              Output1 <= 1'b1;
              TxValid <= 1'b1;
              Busy    <= 1'b1;
            end
          end
        end
        S_PRE: begin
          if (cnt == '0) begin
            state   <= S_SFD;
            cnt     <= SFD_LAST;
            Output1 <= 1'b1;
          end else begin
            cnt     <= cnt - CW'(1);
            Output1 <= ~cnt[0];
          end
        end
        S_SFD: begin
          if (cnt == '0) begin
            state   <= S_DEST;
            cnt     <= ADDR_LAST;
            Output1 <= dest_sh[47];
            crc     <= crc_step(crc, dest_sh[47]);
            dest_sh <= dest_sh << 1;
          end else begin
            cnt     <= cnt - CW'(1);
            Output1 <= 1'b1;
          end
        end
        S_DEST: begin
          if (cnt == '0) begin
            state   <= S_SRC;
            cnt     <= ADDR_LAST;
            Output1 <= src_sh[47];
            crc     <= crc_step(crc, src_sh[47]);
            src_sh  <= src_sh << 1;
          end else begin
            cnt     <= cnt - CW'(1);
            Output1 <= dest_sh[47];
            crc     <= crc_step(crc, dest_sh[47]);
            dest_sh <= dest_sh << 1;
          end
        end
        S_SRC: begin
          if (cnt == '0) begin
            state   <= S_TYPE;
            cnt     <= TYPE_LAST;
            Output1 <= type_sh[15];
            crc     <= crc_step(crc, type_sh[15]);
            type_sh <= type_sh << 1;
          end else begin
            cnt     <= cnt - CW'(1);
            Output1 <= src_sh[47];
            crc     <= crc_step(crc, src_sh[47]);
            src_sh  <= src_sh << 1;
          end
        end
        S_TYPE: begin
          if (cnt == '0) begin
            if (len_q == '0) begin
              state   <= S_FCS;
              cnt     <= FCS_LAST;
              Output1 <= ~crc[31];
              crc     <= crc << 1;
            end else begin
              state   <= S_PAY;
              cnt     <= len_q - CW'(1);
              Output1 <= pay_sh[MAX_PAYLOAD-1];
              crc     <= crc_step(crc, pay_sh[MAX_PAYLOAD-1]);
              pay_sh  <= pay_sh << 1;
            end
          end else begin
            cnt     <= cnt - CW'(1);
            Output1 <= type_sh[15];
            crc     <= crc_step(crc, type_sh[15]);
            type_sh <= type_sh << 1;
          end
        end
        S_PAY: begin
          if (cnt == '0) begin
            state   <= S_FCS;
            cnt     <= FCS_LAST;
            Output1 <= ~crc[31];
            crc     <= crc << 1;
          end else begin
            cnt     <= cnt - CW'(1);
            Output1 <= pay_sh[MAX_PAYLOAD-1];
            crc     <= crc_step(crc, pay_sh[MAX_PAYLOAD-1]);
            pay_sh  <= pay_sh << 1;
          end
        end
        S_FCS: begin
          if (cnt == '0) begin
            state   <= S_GAP;
            cnt     <= IFG_LAST;
            Output1 <= 1'b0;
            TxValid <= 1'b0;
            Done    <= 1'b1;
          end else begin
            cnt     <= cnt - CW'(1);
            Output1 <= ~crc[31];
            crc     <= crc << 1;
          end
        end
        S_GAP: begin
          if (cnt == '0) begin
            state <= S_IDLE;
            Busy  <= 1'b0;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        default: begin
          state   <= S_IDLE;
          Output1 <= 1'b0;
          TxValid <= 1'b0;
          Busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ethernet_tx.sv
// Directed bench for ethernet_tx: frame layout, FCS, gap timing, rejects,
// busy-time starts, back-to-back frames and asynchronous reset.
module tb_ethernet_tx;

  localparam int unsigned MAXP = 64;
  localparam int unsigned IFG  = 12;

  logic            Clk;
  logic            Reset;
  logic            Start;
  logic [47:0]     DestAddr;
  logic [47:0]     SrcAddr;
  logic [15:0]     PayloadLen;
  logic [MAXP-1:0] Payload;
  logic            Output1;
  logic            TxValid;
  logic            Busy;
  logic            Done;
  logic            Error;

  ethernet_tx #(.MAX_PAYLOAD(MAXP), .IFG_CYCLES(IFG)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .DestAddr(DestAddr),
    .SrcAddr(SrcAddr), .PayloadLen(PayloadLen), .Payload(Payload),
    .Output1(Output1), .TxValid(TxValid), .Busy(Busy), .Done(Done),
    .Error(Error)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int passed = 0;
  int total  = 0;
  int nfail  = 0;
  int cyc    = 0;
  always @(posedge Clk) cyc++;

  logic        rxbits [0:511];
  logic        expbits[0:511];
  int          rxn, expn, rx_t0;
  logic        rx_done;
  logic [31:0] exp_fcs;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Value of n received bits starting at index s, first bit as MSB.
  function automatic logic [63:0] fld(input int s, input int n);
    logic [63:0] v = '0;
    for (int i = 0; i < n; i++)
      v = {v[62:0], (s + i >= 0 && s + i < 512) ? rxbits[s+i] : 1'bx};
    return v;
  endfunction

  // Reference frame and FCS from the frame layout and CRC-32 definition.
  task automatic build_exp(input logic [47:0] d, input logic [47:0] s,
                           input logic [15:0] len, input logic [63:0] p);
    logic [31:0] c;
    logic        fb;
    int          n = 0;
    for (int i = 0; i < 62; i++) begin expbits[n] = (i % 2 == 0); n++; end
    expbits[n] = 1'b1; n++;
    expbits[n] = 1'b1; n++;
    for (int i = 47; i >= 0; i--) begin expbits[n] = d[i]; n++; end
    for (int i = 47; i >= 0; i--) begin expbits[n] = s[i]; n++; end
    for (int i = 15; i >= 0; i--) begin expbits[n] = len[i]; n++; end
    for (int i = int'(len) - 1; i >= 0; i--) begin expbits[n] = p[i]; n++; end
    c = 32'hFFFF_FFFF;
    for (int i = 64; i < n; i++) begin
      fb = c[31] ^ expbits[i];
      c  = {c[30:0], 1'b0};
      if (fb) c = c ^ 32'h04C1_1DB7;
    end
    exp_fcs = ~c;
    for (int i = 31; i >= 0; i--) begin expbits[n] = exp_fcs[i]; n++; end
    expn = n;
  endtask

  task automatic wait_idle();
    int w = 0;
    while (Busy !== 1'b0 && w < 2000) begin @(negedge Clk); w++; end
    if (Busy !== 1'b0) chk("idle_timeout", 64'(Busy), 64'd0);
  endtask

  // Present a descriptor for one accept edge; scramble inputs afterwards
  // unless Start is to stay held.
  task automatic send(input logic [47:0] d, input logic [47:0] s,
                      input logic [15:0] len, input logic [63:0] p, input bit hold);
    wait_idle();
    DestAddr = d; SrcAddr = s; PayloadLen = len; Payload = p;
    Start = 1'b1;
    @(negedge Clk);
    if (!hold) begin
      Start      = 1'b0;
      DestAddr   = 48'({$urandom(), $urandom()});
      SrcAddr    = 48'({$urandom(), $urandom()});
      PayloadLen = 16'($urandom());
      Payload    = 64'({$urandom(), $urandom()});
    end
  endtask

  task automatic rx_frame(input int poke_at, input bit drop);
    int w = 0;
    rxn = 0;
    rx_done = 1'b0;
    while (TxValid !== 1'b1 && w < 50) begin @(negedge Clk); w++; end
    if (TxValid !== 1'b1) begin
      chk("rx_start_timeout", 64'(TxValid), 64'd1);
    end else begin
      rx_t0 = cyc;
      while (TxValid === 1'b1 && rxn < 400) begin
        rxbits[rxn] = Output1;
        if (rxn == 0 && drop) Start = 1'b0;
        if (rxn == poke_at) begin
          Start    = 1'b1;
          DestAddr = 48'h0123_4567_89AB;
        end else if (rxn == poke_at + 1) begin
          Start = 1'b0;
        end
        rxn++;
        @(negedge Clk);
      end
      rx_done = Done;
    end
  endtask

  task automatic check_frame(input string t);
    int nm = 0;
    chk({t, "_len"}, 64'(rxn), 64'(expn));
    for (int i = 0; i < rxn && i < expn; i++)
      if (rxbits[i] !== expbits[i]) nm++;
    chk({t, "_bits"}, 64'(nm), 64'd0);
    chk({t, "_fcs"}, fld(rxn - 32, 32), 64'(exp_fcs));
    chk({t, "_done"}, 64'(rx_done), 64'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int g, bad, cntv, t1;
    logic [63:0] fcs1;

    Reset = 1'b0; Start = 1'b0; DestAddr = '0; SrcAddr = '0;
    PayloadLen = '0; Payload = '0;
    repeat (3) @(negedge Clk);
    chk("reset_outputs", 64'({Output1, TxValid, Busy, Done, Error}), 64'd0);
    Reset = 1'b1;
    @(negedge Clk);

    // Basic frame with a 4-bit payload.
    build_exp(48'hFFFF_FFFF_FFFF, 48'hAAAA_AAAA_AAAA, 16'd4, 64'h8);
    send(48'hFFFF_FFFF_FFFF, 48'hAAAA_AAAA_AAAA, 16'd4, 64'h8, 1'b0);
    rx_frame(-10, 1'b0);
    check_frame("basic");
    chk("basic_len_212", 64'(rxn), 64'd212);
    chk("basic_preamble", fld(0, 62), 64'h2AAA_AAAA_AAAA_AAAA);
    chk("basic_sfd", fld(62, 2), 64'h3);
    chk("basic_type", fld(160, 16), 64'h0004);
    chk("basic_payload", fld(176, 4), 64'h8);
    g = 0; bad = 0;
    while (Busy === 1'b1 && g < 100) begin
      if (Output1 !== 1'b0 || TxValid !== 1'b0) bad++;
      g++;
      @(negedge Clk);
    end
    chk("basic_gap_cycles", 64'(g), 64'(IFG));
    chk("basic_gap_quiet", 64'(bad), 64'd0);

    // Zero-length payload: TYPE straight into FCS.
    build_exp(48'h0011_2233_4455, 48'h6677_8899_AABB, 16'd0, 64'h0);
    send(48'h0011_2233_4455, 48'h6677_8899_AABB, 16'd0, 64'h0, 1'b0);
    rx_frame(-10, 1'b0);
    check_frame("zero");
    chk("zero_len_208", 64'(rxn), 64'd208);
    chk("zero_type", fld(160, 16), 64'h0000);

    // Largest legal payload.
    build_exp(48'h1234_5678_9ABC, 48'hFEDC_BA98_7654, 16'd64, 64'hDEAD_BEEF_0123_4567);
    send(48'h1234_5678_9ABC, 48'hFEDC_BA98_7654, 16'd64, 64'hDEAD_BEEF_0123_4567, 1'b0);
    rx_frame(-10, 1'b0);
    check_frame("max");
    chk("max_len_272", 64'(rxn), 64'd272);

    // Oversize payload length is rejected.
    wait_idle();
    PayloadLen = 16'd65;
    Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    chk("ovs_error", 64'(Error), 64'd1);
    chk("ovs_busy", 64'(Busy), 64'd0);
    chk("ovs_line", 64'({Output1, TxValid}), 64'd0);
    @(negedge Clk);
    chk("ovs_error_clear", 64'(Error), 64'd0);
    cntv = 0;
    repeat (10) begin
      if (TxValid !== 1'b0 || Busy !== 1'b0 || Output1 !== 1'b0) cntv++;
      @(negedge Clk);
    end
    chk("ovs_stays_idle", 64'(cntv), 64'd0);

    // Start pulsed mid-frame (bit 100) with a new address is ignored.
    build_exp(48'hA1B2_C3D4_E5F6, 48'h0F0F_0F0F_0F0F, 16'd8, 64'hA5);
    send(48'hA1B2_C3D4_E5F6, 48'h0F0F_0F0F_0F0F, 16'd8, 64'hA5, 1'b0);
    rx_frame(99, 1'b0);
    check_frame("busy");
    cntv = 0;
    repeat (300) begin
      if (TxValid === 1'b1) cntv++;
      @(negedge Clk);
    end
    chk("busy_no_second_frame", 64'(cntv), 64'd0);

    // Start held high: back-to-back frames one IFG apart.
    build_exp(48'h0A0B_0C0D_0E0F, 48'h1020_3040_5060, 16'd4, 64'h5);
    send(48'h0A0B_0C0D_0E0F, 48'h1020_3040_5060, 16'd4, 64'h5, 1'b1);
    rx_frame(-10, 1'b0);
    t1 = rx_t0;
    fcs1 = fld(rxn - 32, 32);
    check_frame("b2b_first");
    rx_frame(-10, 1'b1);
    check_frame("b2b_second");
    chk("b2b_spacing", 64'(rx_t0 - t1), 64'd225);
    chk("b2b_fcs_same", fld(rxn - 32, 32), fcs1);

    // Asynchronous reset during DEST bit 20, then a fresh frame.
    wait_idle();
    DestAddr = 48'hFFFF_FFFF_FFFF; SrcAddr = 48'hAAAA_AAAA_AAAA;
    PayloadLen = 16'd4; Payload = 64'h8;
    Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    repeat (83) @(negedge Clk);
    chk("pre_reset_txvalid", 64'(TxValid), 64'd1);
    #2 Reset = 1'b0;
    #1 chk("async_reset_outputs", 64'({Output1, TxValid, Busy, Done, Error}), 64'd0);
    @(negedge Clk);
    Reset = 1'b1;
    build_exp(48'hFFFF_FFFF_FFFF, 48'hAAAA_AAAA_AAAA, 16'd4, 64'h8);
    send(48'hFFFF_FFFF_FFFF, 48'hAAAA_AAAA_AAAA, 16'd4, 64'h8, 1'b0);
    rx_frame(-10, 1'b0);
    check_frame("after_reset");
    chk("after_reset_first_bit", 64'(rxbits[0]), 64'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
